// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM. Each accepted access
// holds the RAM pins for WAIT_CYCLES+1 cycles, then pulses the granted port's done.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_enable,
  output logic              mem_R_W,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_D_In,
  input  logic [DATA_W-1:0] mem_D_Out,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  // Port encoding for gnt/last_gnt: 0 = A, 1 = B.
  logic              gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              r_w_q, r_w_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    wait_cnt_d = wait_cnt_q;
    r_w_d      = r_w_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          // On a tie, the port not served last time wins.
          gnt_d      = (a_req && b_req) ? ~last_gnt_q : b_req;
          last_gnt_d = gnt_d;
          r_w_d      = gnt_d ? b_we : a_we;
          addr_d     = gnt_d ? b_addr : a_addr;
          wdata_d    = gnt_d ? b_wdata : a_wdata;
          wait_cnt_d = 4'(WAIT_CYCLES);
          state_d    = StAccess;
        end
      end
      StAccess: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          state_d = StDone;
          if (!r_w_q) begin
            if (gnt_q) b_rdata_d = mem_D_Out;
            else       a_rdata_d = mem_D_Out;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      wait_cnt_q <= 4'd0;
      r_w_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      wait_cnt_q <= wait_cnt_d;
      r_w_q      <= r_w_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign mem_enable  = (state_q == StAccess);
  assign mem_R_W     = r_w_q;
  assign mem_Address = addr_q;
  assign mem_D_In    = wdata_q;
  assign a_done      = (state_q == StDone) && !gnt_q;
  assign b_done      = (state_q == StDone) && gnt_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: one arbiter with WAIT_CYCLES=0 and one with WAIT_CYCLES=2,
// each in front of a small behavioural RAM.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance 0: WAIT_CYCLES = 0
  logic        rst, a_req, a_we, b_req, b_we, a_done, b_done;
  logic [15:0] a_addr, b_addr, m_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, m_din, m_dout;
  logic        m_en, m_rw, busy;
  logic [31:0] ram0 [16];

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .mem_enable(m_en), .mem_R_W(m_rw), .mem_Address(m_addr), .mem_D_In(m_din),
    .mem_D_Out(m_dout), .busy(busy)
  );

  assign m_dout = ram0[m_addr[3:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram0[i] <= 32'h0;
      ram0[5] <= 32'h00EE0000;
      ram0[7] <= 32'hFFFF0000;
    end else if (m_en && m_rw) begin
      ram0[m_addr[3:0]] <= m_din;
    end
  end

  // Instance 2: WAIT_CYCLES = 2, port B idle
  logic        rst2, a2_req, a2_done, b2_done, m2_en, m2_rw, busy2;
  logic [15:0] a2_addr, m2_addr;
  logic [31:0] a2_rdata, b2_rdata, m2_din, m2_dout;
  logic [31:0] ram2 [16];

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2),
    .a_req(a2_req), .a_we(1'b0), .a_addr(a2_addr), .a_wdata(32'h0),
    .a_done(a2_done), .a_rdata(a2_rdata),
    .b_req(1'b0), .b_we(1'b0), .b_addr(16'h0), .b_wdata(32'h0),
    .b_done(b2_done), .b_rdata(b2_rdata),
    .mem_enable(m2_en), .mem_R_W(m2_rw), .mem_Address(m2_addr), .mem_D_In(m2_din),
    .mem_D_Out(m2_dout), .busy(busy2)
  );

  assign m2_dout = ram2[m2_addr[3:0]];
  always_ff @(posedge clk) begin
    if (rst2) begin
      for (int i = 0; i < 16; i++) ram2[i] <= 32'h0;
      ram2[7] <= 32'hFFFF0000;
    end else if (m2_en && m2_rw) begin
      ram2[m2_addr[3:0]] <= m2_din;
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    a_addr = 16'd9; b_addr = 16'd10; a_wdata = 32'h0; b_wdata = 32'h0;
    a2_req = 1'b0; a2_addr = 16'd0;

    // Reset held two cycles with both requests high
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rst_busy",  busy, 0);
      check_eq("rst_en",    m_en, 0);
      check_eq("rst_mem",   {m_rw, m_addr, m_din}, 0);
      check_eq("rst_done",  {a_done, b_done}, 0);
      check_eq("rst_rdata", {a_rdata, b_rdata}, 0);
    end
    rst = 1'b0;
    tick();
    check_eq("first_gnt_addr", m_addr, 16'd9);
    check_eq("first_gnt_en", m_en, 1);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    check_eq("first_gnt_done", {a_done, b_done}, 2'b10);
    tick();
    check_eq("first_gnt_idle", busy, 0);

    // Single read of addr 5
    a_req = 1'b1; a_addr = 16'd5;
    tick();
    check_eq("rd_en", {m_en, m_rw, m_addr}, {1'b1, 1'b0, 16'd5});
    a_req = 1'b0;
    tick();
    check_eq("rd_en_off", m_en, 0);
    check_eq("rd_done", {a_done, b_done}, 2'b10);
    check_eq("rd_data", a_rdata, 32'h00EE0000);
    tick();
    check_eq("rd_done_off", {a_done, b_done}, 0);

    // B writes addr 3, then A reads it back
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'd3; b_wdata = 32'hAAAA0000;
    tick();
    check_eq("wr_pins", {m_en, m_rw, m_addr, m_din}, {1'b1, 1'b1, 16'd3, 32'hAAAA0000});
    b_req = 1'b0; b_we = 1'b0;
    tick();
    check_eq("wr_done", {a_done, b_done}, 2'b01);
    check_eq("wr_rdata_keep", b_rdata, 0);
    tick();
    a_req = 1'b1; a_addr = 16'd3;
    tick();
    a_req = 1'b0;
    tick();
    check_eq("rb_done", a_done, 1);
    check_eq("rb_data", a_rdata, 32'hAAAA0000);
    tick();

    // Contention: last grant was A, so B wins the first tie
    a_req = 1'b1; a_addr = 16'd1; b_req = 1'b1; b_addr = 16'd2;
    for (int i = 1; i <= 12; i++) begin
      logic [1:0] exp_done;
      tick();
      exp_done = 2'b00;
      if (i % 3 == 2) exp_done = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
      check_eq($sformatf("cont_done_c%0d", i), {a_done, b_done}, exp_done);
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    tick();
    check_eq("cont_idle", busy, 0);

    // WAIT_CYCLES=2 read of addr 7
    rst2 = 1'b0;
    tick();
    a2_req = 1'b1; a2_addr = 16'd7;
    for (int i = 1; i <= 4; i++) begin
      tick();
      a2_req = 1'b0;
      check_eq($sformatf("w2_en_c%0d", i), m2_en, (i <= 3) ? 1 : 0);
      check_eq($sformatf("w2_done_c%0d", i), {a2_done, b2_done}, (i == 4) ? 2'b10 : 2'b00);
    end
    check_eq("w2_data", a2_rdata, 32'hFFFF0000);
    tick();

    // Reset in the second ACCESS cycle aborts the access
    a2_req = 1'b1;
    tick();
    a2_req = 1'b0;
    tick();
    check_eq("ab_in_access", m2_en, 1);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    check_eq("ab_idle", {busy2, m2_en}, 0);
    check_eq("ab_done", {a2_done, b2_done}, 0);
    check_eq("ab_rdata", a2_rdata, 0);
    tick();
    check_eq("ab_no_late_done", {a2_done, b2_done, busy2}, 0);
    a2_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      a2_req = 1'b0;
    end
    check_eq("ab_retry_done", a2_done, 1);
    check_eq("ab_retry_data", a2_rdata, 32'hFFFF0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
